// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: ctrl/ex inputs, ROM port and IF/ID outputs.
// master = fetch stage side, slave = environment (ctrl, ex, ROM, id).
interface if_stage_if;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_valid_o;

    modport master (
        input  stall_i, branch_flag_i, branch_target_i, rom_data_i,
        output rom_ce_o, rom_addr_o, id_pc_o, id_instr_o, id_valid_o
    );

    modport slave (
        output stall_i, branch_flag_i, branch_target_i, rom_data_i,
        input  rom_ce_o, rom_addr_o, id_pc_o, id_instr_o, id_valid_o
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch with IF/ID register and a one-entry skid buffer.
// Ports: clk, rst (sync, active high), bus (if_stage_if.master).
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic clk,
    input  logic rst,
    if_stage_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_fetch_pc;
    logic        r_inflight_v;
    logic [31:0] r_inflight_pc;
    logic        r_buf_v;
    logic [31:0] r_buf_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;
    logic        r_id_valid;
    logic        w_ce;
    logic [31:0] w_addr;

    // Redirect beats everything but reset, including a stall.
    always_comb begin
        w_ce   = 1'b0;
        w_addr = r_fetch_pc;
        w_next = r_state;
        if (bus.branch_flag_i) begin
            w_ce   = 1'b1;
            w_addr = {bus.branch_target_i[31:2], 2'b00};
            w_next = RUN;
        end else begin
            unique case (r_state)
                IDLE: w_next = RUN;
                RUN: begin
                    if (bus.stall_i) w_next = HOLD;
                    else             w_ce   = 1'b1;
                end
                HOLD: begin
                    if (!bus.stall_i) begin
                        w_ce   = 1'b1;
                        w_next = RUN;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_fetch_pc    <= RESET_PC;
            r_inflight_v  <= 1'b0;
            r_inflight_pc <= 32'h0;
            r_buf_v       <= 1'b0;
            r_buf_pc      <= 32'h0;
            r_buf_instr   <= NOP_INSTR;
            r_id_pc       <= 32'h0;
            r_id_instr    <= NOP_INSTR;
            r_id_valid    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_inflight_v <= w_ce;
            if (w_ce) begin
                r_inflight_pc <= w_addr;
                r_fetch_pc    <= w_addr + 32'd4;
            end
            if (bus.branch_flag_i) begin
                // Wrong-path response and buffered word are dropped.
                r_id_pc    <= 32'h0;
                r_id_instr <= NOP_INSTR;
                r_id_valid <= 1'b0;
                r_buf_v    <= 1'b0;
            end else begin
                unique case (r_state)
                    RUN: begin
                        if (!bus.stall_i) begin
                            if (r_inflight_v) begin
                                r_id_pc    <= r_inflight_pc;
                                r_id_instr <= bus.rom_data_i;
                                r_id_valid <= 1'b1;
                            end else begin
                                r_id_pc    <= 32'h0;
                                r_id_instr <= NOP_INSTR;
                                r_id_valid <= 1'b0;
                            end
                        end else if (r_inflight_v) begin
                            // Catch the response the ROM returns
                            // while id is frozen.
                            r_buf_v     <= 1'b1;
                            r_buf_pc    <= r_inflight_pc;
                            r_buf_instr <= bus.rom_data_i;
                        end
                    end
                    HOLD: begin
                        if (!bus.stall_i) begin
                            r_buf_v <= 1'b0;
                            if (r_buf_v) begin
                                r_id_pc    <= r_buf_pc;
                                r_id_instr <= r_buf_instr;
                                r_id_valid <= 1'b1;
                            end else begin
                                r_id_pc    <= 32'h0;
                                r_id_instr <= NOP_INSTR;
                                r_id_valid <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rom_ce_o   = w_ce;
    assign bus.rom_addr_o = w_addr;
    assign bus.id_pc_o    = r_id_pc;
    assign bus.id_instr_o = r_id_instr;
    assign bus.id_valid_o = r_id_valid;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed plan plus random stall/branch/reset.
// Queue-based fetch model feeds a scoreboard checked at negedge.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic        chk;
        logic        ce;
        logic [31:0] addr;
    } bus_exp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        v;
    } id_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_stage_if bus ();

    if_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    always @(posedge clk)
        if (bus.rom_ce_o) bus.rom_data_i <= rom_word(bus.rom_addr_o);

    bus_exp_t    bus_q[$];
    id_exp_t     id_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] m_q[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_idle = 1'b1;
    id_exp_t     m_id;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic b,
                        input logic [31:0] t);
        bus_exp_t    be;
        logic [31:0] al;
        logic [31:0] p;
        @(posedge clk);
        #1;
        rst                 = r;
        bus.stall_i         = s;
        bus.branch_flag_i   = b;
        bus.branch_target_i = t;
        al      = {t[31:2], 2'b00};
        be.chk  = !r;
        be.ce   = 1'b0;
        be.addr = m_pc;
        if (r) begin
            m_q.delete();
            m_pc   = RESET_PC;
            m_idle = 1'b1;
            m_id   = '{pc: 32'h0, instr: NOP, v: 1'b0};
        end else if (b) begin
            be.ce   = 1'b1;
            be.addr = al;
            m_q.delete();
            m_q.push_back(al);
            m_pc   = al + 32'd4;
            m_idle = 1'b0;
            m_id   = '{pc: 32'h0, instr: NOP, v: 1'b0};
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else if (!s) begin
            be.ce = 1'b1;
            if (m_q.size() > 0) begin
                p    = m_q.pop_front();
                m_id = '{pc: p, instr: rom_word(p), v: 1'b1};
            end else begin
                m_id = '{pc: 32'h0, instr: NOP, v: 1'b0};
            end
            m_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        bus_q.push_back(be);
        id_q.push_back(m_id);
    endtask

    initial begin
        id_exp_t  pend;
        bus_exp_t be;
        bit       have;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (have) begin
                check("id_valid", {31'h0, bus.id_valid_o}, {31'h0, pend.v});
                check("id_pc", bus.id_pc_o, pend.pc);
                check("id_instr", bus.id_instr_o, pend.instr);
                have = 1'b0;
            end
            if (bus_q.size() > 0) begin
                be = bus_q.pop_front();
                if (be.chk) begin
                    check("rom_ce", {31'h0, bus.rom_ce_o}, {31'h0, be.ce});
                    check("rom_addr", bus.rom_addr_o, be.addr);
                end
            end
            if (id_q.size() > 0) begin
                pend = id_q.pop_front();
                have = 1'b1;
            end
        end
    end

    initial begin
        logic r, s, b;
        logic [31:0] t;
        rst                 = 1'b1;
        bus.stall_i         = 1'b0;
        bus.branch_flag_i   = 1'b0;
        bus.branch_target_i = 32'h0;
        // reset and streaming
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        // stall absorb
        repeat (3) step(0, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        // redirect
        step(0, 0, 1, 32'h40);
        repeat (4) step(0, 0, 0, 0);
        // branch during stall
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'h80);
        repeat (4) step(0, 0, 0, 0);
        // misaligned target, then wrap
        step(0, 0, 1, 32'h43);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFFC);
        repeat (3) step(0, 0, 0, 0);
        // reset while holding a buffered word
        repeat (2) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 500; i++) begin
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 10);
            t = ($urandom_range(0, 7) == 0) ?
                32'hFFFF_FFF0 + {28'h0, 4'($urandom)} : $urandom;
            step(r, s, b, t);
        end
        step(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
